// File: rtl/m_fmap_writer_1_pkg.sv
// Shared definitions for the layer-1 feature-map writer and the pooling reader:
// frame geometry, bus widths and the writer state encoding.
package m_fmap_writer_1_pkg;

    localparam int unsigned FmapW      = 26;
    localparam int unsigned FmapH      = 26;
    localparam int unsigned FmapPixels = FmapW * FmapH;
    localparam int unsigned AddrW      = 10;
    localparam int unsigned DataW      = 8;
    localparam int unsigned InW        = 20;
    localparam int unsigned Shift      = 8;

    typedef enum logic [1:0] {
        StWaitSof = 2'd0,
        StFill    = 2'd1,
        StDone    = 2'd2
    } fmap_state_e;

endpackage

// File: rtl/m_fmap_writer_1_requant_relu.sv
// Combinational requantizer: arithmetic shift (optionally rounded when FMAP_ROUND_EN is
// defined), ReLU and saturation of a signed IN_W accumulator down to DATA_W unsigned.
module m_requant_relu #(
    parameter int unsigned IN_W   = 20,
    parameter int unsigned SHIFT  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic [IN_W-1:0]   data,
    output logic [DATA_W-1:0] q
);

    localparam logic signed [IN_W:0] MaxVal = (IN_W + 1)'((1 << DATA_W) - 1);
`ifdef FMAP_ROUND_EN
    localparam logic signed [IN_W:0] Bias = (IN_W + 1)'(1 << (SHIFT - 1));
`endif

    // One extra bit so the rounding bias can never wrap a large positive value.
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] y;

    always_comb begin
        ext = $signed({data[IN_W-1], data});
`ifdef FMAP_ROUND_EN
        ext = ext + Bias;
`endif
        y = ext >>> SHIFT;
        if (y[IN_W]) begin
            q = '0;
        end else if (y > MaxVal) begin
            q = '1;
        end else begin
            q = y[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/m_fmap_writer_1.sv
// Layer-1 feature-map writer: requantizes the conv stream and stores one raster frame,
// then holds it until the pooling stage releases it. Rounding via FMAP_ROUND_EN.
module m_fmap_writer_1
    import m_fmap_writer_1_pkg::*;
#(
    parameter int unsigned IN_W   = InW,
    parameter int unsigned SHIFT  = Shift,
    parameter int unsigned FMAP_W = FmapW,
    parameter int unsigned FMAP_H = FmapH,
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned DATA_W = DataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_valid,
    input  logic              conv_sof,
    input  logic [IN_W-1:0]   conv_data,
    output logic              conv_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] d_out,
    output logic              layer_1_write_complete,
    input  logic              layer_2_ready,
    output logic              sof_err
);

    localparam int unsigned       Pixels    = FMAP_W * FMAP_H;
    localparam logic [ADDR_W-1:0] LastPixel = ADDR_W'(Pixels - 1);

    fmap_state_e       state_q;
    logic [ADDR_W-1:0] count_q;
    logic              ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              complete_q;
    logic              sof_err_q;

    logic [DATA_W-1:0] pixel;
    logic              xfer;

    m_requant_relu #(
        .IN_W   (IN_W),
        .SHIFT  (SHIFT),
        .DATA_W (DATA_W)
    ) u_requant (
        .data (conv_data),
        .q    (pixel)
    );

    assign xfer = conv_valid & ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StWaitSof;
            count_q    <= '0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            complete_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            sof_err_q <= 1'b0;
            unique case (state_q)
                StWaitSof: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        if (conv_sof) begin
                            wr_en_q <= 1'b1;
                            addr_q  <= '0;
                            data_q  <= pixel;
                            count_q <= ADDR_W'(1);
                            state_q <= StFill;
                        end else begin
                            sof_err_q <= 1'b1;
                        end
                    end
                end
                StFill: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        wr_en_q <= 1'b1;
                        data_q  <= pixel;
                        if (conv_sof) begin
                            // Resync: restart the frame with this pixel at address 0.
                            addr_q    <= '0;
                            count_q   <= ADDR_W'(1);
                            sof_err_q <= 1'b1;
                        end else begin
                            addr_q <= count_q;
                            if (count_q == LastPixel) begin
                                count_q <= '0;
                                ready_q <= 1'b0;
                                state_q <= StDone;
                            end else begin
                                count_q <= count_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    // Complete is raised one cycle after entry so the last write lands first.
                    if (complete_q && layer_2_ready) begin
                        complete_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= StWaitSof;
                    end else begin
                        complete_q <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StWaitSof;
                    count_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign conv_ready             = ready_q;
    assign wr_en                  = wr_en_q;
    assign ram_write_addr         = addr_q;
    assign d_out                  = data_q;
    assign layer_1_write_complete = complete_q;
    assign sof_err                = sof_err_q;

`ifndef SYNTHESIS
    a_addr_in_frame: assert property (@(posedge clk) disable iff (!rst)
        wr_en |-> (ram_write_addr <= LastPixel));
    a_no_write_when_complete: assert property (@(posedge clk) disable iff (!rst)
        layer_1_write_complete |-> !wr_en);
    a_no_accept_when_complete: assert property (@(posedge clk) disable iff (!rst)
        layer_1_write_complete |-> !conv_ready);
`endif

endmodule

// File: tb/tb_m_fmap_writer_1.sv
// Randomized self-checking bench for m_fmap_writer_1 against a frame-level reference model.
module tb_m_fmap_writer_1;

    localparam int IN_W   = 20;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int PIXELS = 676;

`ifdef FMAP_ROUND_EN
    localparam logic [7:0] Rq180 = 8'd2;
`else
    localparam logic [7:0] Rq180 = 8'd1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              conv_valid = 1'b0;
    logic              conv_sof = 1'b0;
    logic [IN_W-1:0]   conv_data = '0;
    logic              layer_2_ready = 1'b0;
    logic              conv_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [DATA_W-1:0] d_out;
    logic              layer_1_write_complete;
    logic              sof_err;

    int checks = 0;
    int errors = 0;
    int n_err  = 0;
    int n_wr   = 0;

    always #5 clk = ~clk;

    m_fmap_writer_1 dut (
        .clk                    (clk),
        .rst                    (rst),
        .conv_valid             (conv_valid),
        .conv_sof               (conv_sof),
        .conv_data              (conv_data),
        .conv_ready             (conv_ready),
        .wr_en                  (wr_en),
        .ram_write_addr         (ram_write_addr),
        .d_out                  (d_out),
        .layer_1_write_complete (layer_1_write_complete),
        .layer_2_ready          (layer_2_ready),
        .sof_err                (sof_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_requant(input logic [IN_W-1:0] x);
        longint v;
        v = longint'($signed(x));
`ifdef FMAP_ROUND_EN
        v = v + 128;
`endif
        v = v >>> 8;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Frame-level model: phase 0 waiting for sof, 1 filling, 2 frame held.
    int          phase = 0;
    int          pos = 0;
    bit          m_xfer;
    logic        e_wr = 0, e_err = 0, e_cmp = 0, e_ready = 0;
    logic [9:0]  e_addr = '0;
    logic [7:0]  e_data = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase = 0; pos = 0;
            e_wr = 0; e_err = 0; e_cmp = 0; e_ready = 0; e_addr = '0; e_data = '0;
        end else begin
            m_xfer = conv_valid && e_ready;
            e_wr = 0;
            e_err = 0;
            if (phase == 2) begin
                if (e_cmp && layer_2_ready) begin
                    e_cmp = 0;
                    phase = 0;
                end else begin
                    e_cmp = 1;
                end
            end else if (m_xfer) begin
                if (conv_sof) begin
                    e_err = (phase == 1);
                    pos = 0;
                    phase = 1;
                end
                if (phase == 1) begin
                    e_wr = 1;
                    e_addr = 10'(pos);
                    e_data = ref_requant(conv_data);
                    pos++;
                    if (pos == PIXELS) begin
                        phase = 2;
                        pos = 0;
                    end
                end else begin
                    e_err = 1;
                end
            end
            e_ready = (phase != 2);
        end
    end

    logic [7:0] mem [0:PIXELS-1];
    always @(posedge clk) if (wr_en === 1'b1) mem[ram_write_addr] <= d_out;

    always @(negedge clk) begin
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("ram_write_addr", 32'(ram_write_addr), 32'(e_addr));
        chk("d_out", 32'(d_out), 32'(e_data));
        chk("sof_err", 32'(sof_err), 32'(e_err));
        chk("complete", 32'(layer_1_write_complete), 32'(e_cmp));
        chk("conv_ready", 32'(conv_ready), 32'(e_ready));
        if (sof_err === 1'b1) n_err++;
        if (wr_en === 1'b1) n_wr++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (conv_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(conv_ready), 32'd1);
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic sof);
        wait_ready();
        conv_valid = 1'b1;
        conv_data  = d;
        conv_sof   = sof;
        @(negedge clk);
        conv_valid = 1'b0;
        conv_sof   = 1'b0;
    endtask

    task automatic wait_complete();
        int n = 0;
        while (layer_1_write_complete !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("complete_wait", 32'(layer_1_write_complete), 32'd1);
    endtask

    task automatic release_frame();
        layer_2_ready = 1'b1;
        @(negedge clk);
        layer_2_ready = 1'b0;
        chk("release_complete", 32'(layer_1_write_complete), 32'd0);
        chk("release_ready", 32'(conv_ready), 32'd1);
    endtask

    function automatic logic [IN_W-1:0] rand_data();
        case ($urandom_range(2))
            0: return IN_W'($urandom);
            1: return IN_W'($urandom_range(0, 70000));
            default: return IN_W'(-$signed($urandom_range(0, 2000)));
        endcase
    endfunction

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n0, w0, bad;
        #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_addr", 32'(ram_write_addr), 0);
        chk("rst_d_out", 32'(d_out), 0);
        chk("rst_complete", 32'(layer_1_write_complete), 0);
        chk("rst_ready", 32'(conv_ready), 0);
        chk("rst_sof_err", 32'(sof_err), 0);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        chk("first_ready", 32'(conv_ready), 1);

        // Missing sof: transfers are dropped and flagged.
        n0 = n_err; w0 = n_wr;
        for (int i = 0; i < 3; i++) send(rand_data(), 1'b0);
        idle(3);
        chk("nosof_err_pulses", 32'(n_err - n0), 3);
        chk("nosof_writes", 32'(n_wr - w0), 0);

        // Requant edges, then a random frame with bubbles.
        send(20'hFFFFF, 1'b1);
        chk("rq_minus1", 32'(d_out), 0);
        chk("rq_first_addr", 32'(ram_write_addr), 0);
        send(20'h0FF7F, 1'b0);
        chk("rq_0ff7f", 32'(d_out), 255);
        send(20'h10000, 1'b0);
        chk("rq_10000", 32'(d_out), 255);
        send(20'h00180, 1'b0);
        chk("rq_00180", 32'(d_out), 32'(Rq180));
        send(20'h0017F, 1'b0);
        chk("rq_0017f", 32'(d_out), 1);
        for (int k = 5; k < PIXELS; k++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
            send(rand_data(), 1'b0);
        end
        chk("last_write_addr", 32'(ram_write_addr), 675);
        chk("complete_not_yet", 32'(layer_1_write_complete), 0);
        @(negedge clk);
        chk("complete_t2", 32'(layer_1_write_complete), 1);
        chk("ready_low_done", 32'(conv_ready), 0);

        // Hold the frame without release.
        w0 = n_wr;
        idle(50);
        chk("hold_complete", 32'(layer_1_write_complete), 1);
        chk("hold_writes", 32'(n_wr - w0), 0);
        release_frame();

        // Ramp frame: pixel k carries k<<8.
        for (int k = 0; k < PIXELS; k++) send(IN_W'(k << 8), k == 0);
        chk("ramp_complete_early", 32'(layer_1_write_complete), 0);
        @(negedge clk);
        chk("ramp_complete", 32'(layer_1_write_complete), 1);
        bad = 0;
        for (int k = 0; k < PIXELS; k++) if (mem[k] !== 8'((k < 256) ? k : 255)) bad++;
        chk("ramp_ram_bad_entries", 32'(bad), 0);
        release_frame();

        // Mid-frame sof at pixel 100 restarts the frame.
        send(rand_data(), 1'b1);
        for (int k = 1; k < 100; k++) send(rand_data(), 1'b0);
        send(20'h00500, 1'b1);
        chk("resync_addr", 32'(ram_write_addr), 0);
        chk("resync_err", 32'(sof_err), 1);
        chk("resync_data", 32'(d_out), 5);
        for (int k = 1; k < PIXELS; k++) send(rand_data(), 1'b0);
        @(negedge clk);
        chk("resync_complete", 32'(layer_1_write_complete), 1);
        release_frame();

        // Reset during pixel 300.
        for (int k = 0; k < 300; k++) send(rand_data(), k == 0);
        wait_ready();
        conv_valid = 1'b1;
        conv_data  = rand_data();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_wr_en", 32'(wr_en), 0);
        chk("async_addr", 32'(ram_write_addr), 0);
        chk("async_d_out", 32'(d_out), 0);
        chk("async_complete", 32'(layer_1_write_complete), 0);
        chk("async_ready", 32'(conv_ready), 0);
        chk("async_sof_err", 32'(sof_err), 0);
        conv_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(conv_ready), 1);
        chk("post_reset_complete", 32'(layer_1_write_complete), 0);

        // Full random frame with bubbles and stray layer_2_ready.
        for (int k = 0; k < PIXELS; k++) begin
            layer_2_ready = 1'($urandom_range(1));
            if ($urandom_range(2) == 0) idle($urandom_range(1, 4));
            send(rand_data(), k == 0);
        end
        layer_2_ready = 1'b0;
        wait_complete();
        release_frame();

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
